// File: rtl/pll_lock_ctrl_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// The master side drives the PLL lock status and relock requests; the
// slave side is the sequencer, which returns the PLL/system resets and status.
interface pll_lock_ctrl_if;
    logic       locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    modport master (
        output locked, relock_req,
        input  pll_rst, sys_rst_n, ready, fail, retry_cnt, state
    );

    modport slave (
        input  locked, relock_req,
        output pll_rst, sys_rst_n, ready, fail, retry_cnt, state
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL reset and lock sequencer. Pulses the PLL reset and waits for lock,
// retrying on timeout. Once lock has been continuously stable for
// LOCK_STABLE cycles, it releases the system reset. Loss of lock or a
// relock request re-sequences the PLL. After MAX_RETRY timeouts the
// sequencer parks in FAIL.
module pll_lock_ctrl #(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int LOCK_STABLE  = 50000,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 20
) (
    input  logic          refclk,
    input  logic          rst_n,
    pll_lock_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_END   = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    state_t           st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       retry, retry_nxt;
    logic             lock_meta, lock_s;

    // Bring the asynchronous PLL lock into the refclk domain.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.locked;
            lock_s    <= lock_meta;
        end
    end

    // State, phase counter and retry count registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= PLL_RST;
            cnt   <= '0;
            retry <= '0;
        end else begin
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
        end
    end

    // Sequencing rules. A relock request overrides every other transition,
    // and lock arriving on the timeout cycle takes precedence over the retry.
    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        if (bus.relock_req) begin
            st_nxt    = PLL_RST;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (st)
                PLL_RST: begin
                    if (cnt == PULSE_END) begin
                        st_nxt  = WAIT_LOCK;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        st_nxt  = STABLE;
                        cnt_nxt = '0;
                    end else if (cnt == TIMEOUT_END) begin
                        cnt_nxt = '0;
                        if (retry == RETRY_MAX) begin
                            st_nxt = FAIL;
                        end else begin
                            st_nxt    = PLL_RST;
                            retry_nxt = retry + 4'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        st_nxt  = WAIT_LOCK;
                        cnt_nxt = '0;
                    end else if (cnt == STABLE_END) begin
                        st_nxt    = RUN;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        st_nxt  = PLL_RST;
                        cnt_nxt = '0;
                    end
                end
                FAIL: begin
                    st_nxt = FAIL;
                end
                default: begin
                    st_nxt    = PLL_RST;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            endcase
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        bus.pll_rst   = 1'b0;
        bus.sys_rst_n = 1'b0;
        bus.ready     = 1'b0;
        bus.fail      = 1'b0;
        bus.retry_cnt = retry;
        bus.state     = st;
        case (st)
            PLL_RST: bus.pll_rst = 1'b1;
            RUN: begin
                bus.sys_rst_n = 1'b1;
                bus.ready     = 1'b1;
            end
            FAIL:    bus.fail = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl. Directed test-plan steps and a randomized
// lock/relock phase are checked every cycle against a phase-and-elapsed-time
// reference model.
module tb_pll_lock_ctrl;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int LS = 8;
    localparam int MR = 2;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    logic refclk = 1'b0;
    logic rst_n;

    pll_lock_ctrl_if bus();

    pll_lock_ctrl #(
        .RST_PULSE(RP),
        .LOCK_TIMEOUT(TO),
        .LOCK_STABLE(LS),
        .MAX_RETRY(MR),
        .CNT_W(8)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 refclk = ~refclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current phase, cycles already spent in it,
    // timeouts so far, and the two-cycle delayed view of locked.
    int   m_phase;
    int   m_age;
    int   m_retry;
    logic m_s1;
    logic m_s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_RST;
        m_age   = 0;
        m_retry = 0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
    endtask

    task automatic go(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    task automatic model_clock();
        logic seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.locked;
        if (bus.relock_req) begin
            m_retry = 0;
            go(P_RST);
        end else begin
            case (m_phase)
                P_RST: begin
                    m_age++;
                    if (m_age == RP) go(P_WAIT);
                end
                P_WAIT: begin
                    if (seen) go(P_STABLE);
                    else begin
                        m_age++;
                        if (m_age == TO) begin
                            if (m_retry == MR) go(P_FAIL);
                            else begin
                                m_retry++;
                                go(P_RST);
                            end
                        end
                    end
                end
                P_STABLE: begin
                    if (!seen) go(P_WAIT);
                    else begin
                        m_age++;
                        if (m_age == LS) begin
                            m_retry = 0;
                            go(P_RUN);
                        end
                    end
                end
                P_RUN: if (!seen) go(P_RST);
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},     bus.state,     m_phase);
        chk({tag, ".pll_rst"},   bus.pll_rst,   m_phase == P_RST);
        chk({tag, ".sys_rst_n"}, bus.sys_rst_n, m_phase == P_RUN);
        chk({tag, ".ready"},     bus.ready,     m_phase == P_RUN);
        chk({tag, ".fail"},      bus.fail,      m_phase == P_FAIL);
        chk({tag, ".retry_cnt"}, bus.retry_cnt, m_retry);
    endtask

    task automatic step(input int n, input string tag);
        repeat (n) begin
            @(posedge refclk);
            if (rst_n) model_clock();
            else       model_reset();
            #1;
            check_all(tag);
        end
    endtask

    task automatic wait_state(input int target, input int budget, input string tag, output int n);
        n = 0;
        do begin
            step(1, tag);
            n++;
        end while (bus.state !== 3'(target) && n < budget);
        chk({tag, ".reached"}, bus.state, target);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        int n;
        int hold;

        rst_n          = 1'b1;
        bus.locked     = 1'b0;
        bus.relock_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        step(2, "reset.hold");
        rst_n = 1'b1;

        // Nominal lock sequence.
        wait_state(P_WAIT, 50, "nom.pulse", n);
        chk("nom.pulse_len", n, RP);
        step(10, "nom.wait");
        bus.locked = 1'b1;
        wait_state(P_STABLE, 20, "nom.sync", n);
        chk("nom.sync_lat", n, 3);
        wait_state(P_RUN, 40, "nom.stable", n);
        chk("nom.release_lat", n, LS);
        step(5, "nom.run");

        // Loss of lock in RUN, then an unstable relock.
        bus.locked = 1'b0;
        wait_state(P_RST, 20, "loss", n);
        chk("loss.lat", n, 3);
        step(6, "loss.reseq");
        bus.locked = 1'b1;
        wait_state(P_STABLE, 20, "loss.relock", n);
        step(5, "unstable.cnt5");
        bus.locked = 1'b0;
        step(3, "unstable.drop");
        bus.locked = 1'b1;
        chk("unstable.state", bus.state, P_WAIT);
        chk("unstable.retry", bus.retry_cnt, 0);
        wait_state(P_RUN, 40, "unstable.recover", n);
        step(3, "unstable.run");

        // Asynchronous reset while running.
        async_reset("arst.run");
        bus.locked = 1'b0;
        step(2, "arst.hold");
        rst_n = 1'b1;

        // Lock never arrives: retries then FAIL.
        wait_state(P_FAIL, 200, "tmo", n);
        chk("tmo.cycles", n, (MR + 1) * (RP + TO));
        step(5, "tmo.park");
        bus.relock_req = 1'b1;
        step(1, "relock");
        bus.relock_req = 1'b0;
        chk("relock.fail", bus.fail, 0);
        chk("relock.state", bus.state, P_RST);

        // Relock coincident with the final timeout wins over FAIL.
        step(71, "prio.run");
        chk("prio.pre_state", bus.state, P_WAIT);
        chk("prio.pre_retry", bus.retry_cnt, MR);
        bus.relock_req = 1'b1;
        step(1, "prio.edge");
        bus.relock_req = 1'b0;
        chk("prio.state", bus.state, P_RST);
        chk("prio.retry", bus.retry_cnt, 0);

        // Asynchronous reset while in STABLE.
        bus.locked = 1'b1;
        wait_state(P_STABLE, 40, "arst.to_stable", n);
        step(3, "arst.stable_cnt");
        async_reset("arst.stable");
        chk("arst.pll_rst", bus.pll_rst, 1);
        step(1, "arst.hold2");
        rst_n = 1'b1;

        // Randomized lock behaviour with occasional relock requests.
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                bus.locked = ($urandom_range(0, 9) < 7);
                hold = $urandom_range(1, 25);
            end
            hold--;
            bus.relock_req = ($urandom_range(0, 63) == 0);
            step(1, "rand");
        end
        bus.relock_req = 1'b0;
        step(2, "rand.tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Reset and lock sequencer for the system PLL. Drives the PLL's `rst` input, monitors its asynchronous `locked` output, and releases the design-wide reset only after lock has been continuously stable for a programmable time. It retries on lock timeout, re-sequences on loss of lock or on a relock request, and reports a sticky failure after too many retries. Runs on the PLL reference clock, which is valid before the PLL outputs are.

## Interface
- `RST_PULSE`, 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 500000: cycles to wait for lock before retrying (10 ms at 50 MHz, ≥1).
- `LOCK_STABLE`, 50000: cycles lock must stay continuously high before release (1 ms, ≥1).
- `MAX_RETRY`, 3: timeouts tolerated before FAIL (0..15).
- `CNT_W`, 20: counter width; must hold max(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE)−1.
- `refclk`  in  1  50 MHz reference clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `locked`  in  1  PLL lock, asynchronous to refclk.
- `relock_req`  in  1  synchronous level/pulse; any cycle high requests a full re-sequence.
- `pll_rst`  out  1  to PLL `rst`, active high.
- `sys_rst_n`  out  1  active-low reset for the rest of the design; each consumer clock domain re-synchronises its deassertion.
- `ready`  out  1  high only in RUN.
- `fail`  out  1  high only in FAIL.
- `retry_cnt`  out  4  timeouts in the current sequence.
- `state`  out  3  debug: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

## Operation
- `locked` passes through a 2-flop synchroniser (`lock_s`). The reset value of both flops is 0.
- All outputs decode from registered state and `retry_cnt` only. There is no combinational input-to-output path.
- Decode per state:
  - PLL_RST: `pll_rst`=1.
  - RUN: `sys_rst_n`=1, `ready`=1.
  - FAIL: `fail`=1.
  - All other outputs are 0 in each state.
- Reset values: state=PLL_RST, cnt=0, `retry_cnt`=0. Therefore `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0.
- PLL_RST:
  - cnt increments each cycle.
  - At cnt==RST_PULSE−1, go to WAIT_LOCK with cnt=0.
- WAIT_LOCK:
  - If `lock_s`=1, go to STABLE with cnt=0.
  - Else, at cnt==LOCK_TIMEOUT−1: if `retry_cnt`==MAX_RETRY, go to FAIL. Otherwise increment `retry_cnt` and go to PLL_RST with cnt=0.
  - Else cnt++.
- STABLE:
  - If `lock_s`=0, go to WAIT_LOCK with cnt=0. The glitch is not counted as a retry.
  - Else, at cnt==LOCK_STABLE−1, go to RUN with cnt=0 and `retry_cnt`=0.
  - Else cnt++.
- RUN: if `lock_s`=0, go to PLL_RST with cnt=0.
- FAIL: stays in FAIL until `relock_req` or reset.
- `relock_req`=1 has priority over every other transition in every state. It forces PLL_RST with cnt=0 and `retry_cnt`=0.
  - In PLL_RST this restarts the pulse.
  - In FAIL this clears `fail` on the next cycle.
- Simultaneous events:
  - `relock_req` together with a lock loss or a timeout in the same cycle: the relock rule applies.
  - Lock arriving on the timeout cycle: lock wins and the state goes to STABLE.
- `rst_n` asserted mid-sequence: immediate asynchronous return to reset values, including the synchroniser.

## Timing
- After `rst_n` rises, `pll_rst` stays high for exactly RST_PULSE rising edges.
- `locked` rising at input → STABLE entered at the 3rd refclk edge (2 synchroniser edges + 1 state edge).
- Minimum reset release latency: `sys_rst_n` rises LOCK_STABLE cycles after STABLE is entered.
- `locked` falling in RUN → `sys_rst_n` low and `pll_rst` high by the 3rd edge.
- Glitches on `locked` shorter than one refclk period may be missed. This is acceptable.
- Time to FAIL with lock never asserted: (MAX_RETRY+1)·(RST_PULSE+LOCK_TIMEOUT) cycles after reset release.

## Test plan
Bench parameters: RST_PULSE=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.
- Nominal: reset released, `locked` rises 10 cycles after `pll_rst` falls → `pll_rst` high for 4 cycles; STABLE entered 3 edges after `locked` rises; `sys_rst_n`=`ready`=1 8 cycles later; `retry_cnt`=0.
- Timeout/retry: `locked` held 0 → 3 pulses of `pll_rst`, each 4 cycles and 20 cycles apart; `retry_cnt` steps 0→1→2; FAIL at cycle 72, with `fail`=1 and `sys_rst_n`=0; then `relock_req` one cycle → PLL_RST, `fail`=0, `retry_cnt`=0.
- Unstable lock: `locked` drops for 3 cycles at STABLE cnt=5 → back to WAIT_LOCK, `retry_cnt` unchanged, `sys_rst_n` stays 0; a later stable lock → RUN after 8 full cycles.
- Loss in RUN: `locked` falls → `sys_rst_n`=0 and `pll_rst`=1 within 3 edges; a full sequence repeats.
- Priority: `relock_req` coincides with the WAIT_LOCK timeout cycle at `retry_cnt`=2 → PLL_RST (not FAIL), `retry_cnt`=0.
- Async reset: `rst_n` pulsed low in RUN and in STABLE → all outputs return to reset values with no clock edge; `pll_rst`=1.
